// File: rtl/spi_seq_pkg.sv
// Shared word width and FSM state encoding for the SPI frame sequencer.
package spi_seq_pkg;

  localparam int SPI_WORD_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_WAIT_DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/spi_seq_fifo.sv
// Word buffer for the SPI frame sequencer: storage, wrap-bit pointers, level, full/empty.
module spi_seq_fifo
  import spi_seq_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic                        pop,
  input  logic [SPI_WORD_W-1:0]       wr_data,
  output logic [SPI_WORD_W-1:0]       rd_data,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(DEPTH):0]      level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [SPI_WORD_W-1:0] mem_q [DEPTH];
  logic [LW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  push_s, pop_s;

  // Pointers carry one wrap bit above the index so full and empty stay distinguishable.
  assign level   = wr_ptr_q - rd_ptr_q;
  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == {LW{1'b0}});
  assign push_s  = push & ~full;
  assign pop_s   = pop & ~empty;
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointer values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + LW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + LW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {LW{1'b0}};
      rd_ptr_q <= {LW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Word storage.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/spi_frame_sequencer.sv
// Feeds buffered 24-bit words to an SPI serializer via a load/done handshake.
// Optional frame counter enabled by macro SPI_SEQ_FRAME_CNT_EN.
module spi_frame_sequencer
  import spi_seq_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [SPI_WORD_W-1:0]         wr_data,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          load_data,
  output logic [SPI_WORD_W-1:0]         data_out,
  input  logic                          done_send,
  output logic                          busy,
  output logic                          timeout_err,
  input  logic                          clear_err,
  output logic [15:0]                   frames_sent
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  seq_state_e              state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    ds_sync;
  logic [TW-1:0]           cnt_q, cnt_d;
  logic [SPI_WORD_W-1:0]   data_q, data_d;
  logic [SPI_WORD_W-1:0]   rd_data_s;
  logic                    load_q, load_d;
  logic                    busy_q, busy_d;
  logic                    err_q, err_d;
  logic                    pop_s, tmo_s, frame_done_s;

  spi_seq_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (wr_en),
    .pop     (pop_s),
    .wr_data (wr_data),
    .rd_data (rd_data_s),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign ds_sync     = sync_q[SYNC_STAGES-1];
  assign load_data   = load_q;
  assign data_out    = data_q;
  assign busy        = busy_q;
  assign timeout_err = err_q;

  // Handshake FSM; the timeout counter restarts on every phase entry.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    pop_s        = 1'b0;
    tmo_s        = 1'b0;
    frame_done_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && ds_sync) begin
          state_d = ST_LOAD;
          pop_s   = 1'b1;
          data_d  = rd_data_s;
          cnt_d   = {TW{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (!ds_sync) begin
          state_d = ST_WAIT_DONE;
          cnt_d   = {TW{1'b0}};
        end else if (cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_IDLE;
          tmo_s   = 1'b1;
        end else begin
          cnt_d   = cnt_q + TW'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (ds_sync) begin
          state_d      = ST_IDLE;
          frame_done_s = 1'b1;
        end else if (cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_IDLE;
          tmo_s   = 1'b1;
        end else begin
          cnt_d   = cnt_q + TW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    load_d = (state_d == ST_LOAD);
    busy_d = (state_d != ST_IDLE);
    if (tmo_s) begin
      err_d = 1'b1;
    end else if (clear_err) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // State, handshake outputs and done_send synchronizer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sync_q  <= {SYNC_STAGES{1'b0}};
      cnt_q   <= {TW{1'b0}};
      data_q  <= {SPI_WORD_W{1'b0}};
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[SYNC_STAGES-2:0], done_send};
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      load_q  <= load_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

`ifdef SPI_SEQ_FRAME_CNT_EN
  logic [15:0] frames_q;

  // Completed-frame counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frames_q <= 16'h0000;
    end else if (frame_done_s) begin
      frames_q <= frames_q + 16'h0001;
    end else begin
      frames_q <= frames_q;
    end
  end

  assign frames_sent = frames_q;
`else
  logic unused_frame_done_s;
  assign unused_frame_done_s = frame_done_s;
  assign frames_sent         = 16'h0000;
`endif

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Directed self-checking bench for spi_frame_sequencer (main instance plus a short-timeout instance).
module tb_spi_frame_sequencer;

`ifdef SPI_SEQ_FRAME_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk, rst_n, wr_en, done_send, clear_err;
  logic [23:0] wr_data;

  logic        fifo_full, fifo_empty, load_data, busy, timeout_err;
  logic [3:0]  fifo_level;
  logic [23:0] data_out;
  logic [15:0] frames_sent;

  logic        t_fifo_full, t_fifo_empty, t_load_data, t_busy, t_timeout_err;
  logic [3:0]  t_fifo_level;
  logic [23:0] t_data_out;
  logic [15:0] t_frames_sent;

  logic [23:0] exp_q [0:15];
  int checks = 0;
  int errors = 0;

  spi_frame_sequencer #(.FIFO_DEPTH(8), .SYNC_STAGES(2), .TIMEOUT_CYCLES(4096)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_level(fifo_level),
    .load_data(load_data), .data_out(data_out), .done_send(done_send),
    .busy(busy), .timeout_err(timeout_err), .clear_err(clear_err),
    .frames_sent(frames_sent)
  );

  spi_frame_sequencer #(.FIFO_DEPTH(8), .SYNC_STAGES(2), .TIMEOUT_CYCLES(16)) dut_tmo (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .fifo_full(t_fifo_full), .fifo_empty(t_fifo_empty), .fifo_level(t_fifo_level),
    .load_data(t_load_data), .data_out(t_data_out), .done_send(done_send),
    .busy(t_busy), .timeout_err(t_timeout_err), .clear_err(clear_err),
    .frames_sent(t_frames_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n = 1'b0; wr_en = 1'b0; clear_err = 1'b0; wr_data = 24'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic push_word(input logic [23:0] d);
    wr_en = 1'b1; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Serializer model: drops done_send 3 cycles after each load pulse, raises it hold cycles later.
  task automatic serve_frames(input int n, input int hold, output int pulses, output int bad, output bit fin);
    logic prev;
    int cur, t_load, t_rise;
    prev = 1'b0; cur = -1; t_load = -1; t_rise = -1;
    pulses = 0; bad = 0; fin = 1'b0;
    for (int c = 0; c < n * 100; c++) begin
      @(negedge clk);
      if (load_data && !prev) begin pulses++; cur++; t_load = c; end
      prev = load_data;
      if (busy && cur >= 0 && cur < n && data_out !== exp_q[cur]) bad++;
      if (t_load >= 0 && c == t_load + 3) done_send = 1'b0;
      if (t_load >= 0 && c == t_load + 3 + hold) begin done_send = 1'b1; t_rise = c; end
      if (cur == n - 1 && t_rise > t_load && c > t_rise + 4 && !busy) begin fin = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_en = 1'b0; clear_err = 1'b0; wr_data = 24'h0; done_send = 1'b1;
    @(negedge clk);
    checks++;
    if ({load_data, busy, timeout_err, fifo_empty, fifo_full} !== 5'b00010 || fifo_level !== 4'd0 ||
        data_out !== 24'h0 || frames_sent !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: load=%b busy=%b err=%b empty=%b full=%b level=%0d data=%h frames=%0d, want 0 0 0 1 0 0 000000 0",
               load_data, busy, timeout_err, fifo_empty, fifo_full, fifo_level, data_out, frames_sent);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single_frame();
    int pulses, bad; bit fin;
    done_send = 1'b1; do_reset();
    exp_q[0] = 24'hA5C3F0;
    push_word(24'hA5C3F0);
    serve_frames(1, 40, pulses, bad, fin);
    checks++;
    if (!fin || pulses != 1) begin errors++; $display("FAIL single_pulses: got %0d fin=%b, want 1 fin=1", pulses, fin); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL single_data: %0d cycles off 0xa5c3f0", bad); end
    checks++;
    if (frames_sent !== (CNT_EN ? 16'd1 : 16'd0)) begin errors++; $display("FAIL single_frames: got %0d want %0d", frames_sent, CNT_EN ? 1 : 0); end
    checks++;
    if (data_out !== 24'hA5C3F0) begin errors++; $display("FAIL single_hold: data_out %h want a5c3f0", data_out); end
  endtask

  task automatic test_burst();
    int pulses, bad; bit fin;
    done_send = 1'b0; do_reset();
    for (int i = 0; i < 8; i++) begin
      exp_q[i] = 24'(i + 1);
      push_word(24'(i + 1));
    end
    checks++;
    if (fifo_full !== 1'b1 || fifo_level !== 4'd8) begin errors++; $display("FAIL burst_full: full=%b level=%0d want 1 8", fifo_full, fifo_level); end
    push_word(24'h000009);
    checks++;
    if (fifo_full !== 1'b1 || fifo_level !== 4'd8) begin errors++; $display("FAIL burst_ninth: full=%b level=%0d want 1 8", fifo_full, fifo_level); end
    done_send = 1'b1;
    serve_frames(8, 5, pulses, bad, fin);
    checks++;
    if (!fin || pulses != 8 || bad != 0) begin errors++; $display("FAIL burst_order: pulses=%0d bad=%0d fin=%b want 8 0 1", pulses, bad, fin); end
    checks++;
    if (fifo_empty !== 1'b1 || frames_sent !== (CNT_EN ? 16'd8 : 16'd0)) begin
      errors++; $display("FAIL burst_end: empty=%b frames=%0d want 1 %0d", fifo_empty, frames_sent, CNT_EN ? 8 : 0);
    end
  endtask

  task automatic test_post_reset_gating();
    int viol, pulses, bad; bit fin;
    done_send = 1'b0; do_reset();
    exp_q[0] = 24'h123456;
    push_word(24'h123456);
    viol = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (load_data !== 1'b0) viol++;
    end
    checks++;
    if (viol != 0) begin errors++; $display("FAIL gate_hold: load_data high %0d cycles, want 0", viol); end
    done_send = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (load_data !== 1'b0) begin errors++; $display("FAIL gate_sync: load_data %b before ds_sync, want 0", load_data); end
    serve_frames(1, 10, pulses, bad, fin);
    checks++;
    if (!fin || pulses != 1 || bad != 0) begin errors++; $display("FAIL gate_release: pulses=%0d bad=%0d fin=%b want 1 0 1", pulses, bad, fin); end
  endtask

  task automatic test_timeout();
    int highs;
    done_send = 1'b1; do_reset();
    push_word(24'hBEEF01);
    highs = 0;
    for (int c = 0; c < 60 && highs < 16; c++) begin
      @(negedge clk);
      if (t_load_data) highs++;
    end
    @(negedge clk);
    checks++;
    if (highs != 16 || t_load_data !== 1'b0) begin errors++; $display("FAIL tmo_len: high %0d cycles then load=%b, want 16 then 0", highs, t_load_data); end
    checks++;
    if (t_timeout_err !== 1'b1 || t_busy !== 1'b0 || t_fifo_empty !== 1'b1 || t_frames_sent !== 16'd0) begin
      errors++; $display("FAIL tmo_flags: err=%b busy=%b empty=%b frames=%0d want 1 0 1 0", t_timeout_err, t_busy, t_fifo_empty, t_frames_sent);
    end
    clear_err = 1'b1; @(negedge clk); clear_err = 1'b0;
    checks++;
    if (t_timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_clear: err=%b want 0", t_timeout_err); end
    push_word(24'hBEEF02);
    highs = 0;
    for (int c = 0; c < 60 && highs < 16; c++) begin
      @(negedge clk);
      if (t_load_data) highs++;
    end
    clear_err = 1'b1; @(negedge clk); clear_err = 1'b0;
    checks++;
    if (t_timeout_err !== 1'b1 || t_load_data !== 1'b0) begin
      errors++; $display("FAIL tmo_clear_race: err=%b load=%b want 1 0", t_timeout_err, t_load_data);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit seen;
    done_send = 1'b1; do_reset();
    for (int i = 0; i < 4; i++) push_word(24'(24'h100 + i));
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin @(negedge clk); seen = load_data; end
    done_send = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin @(negedge clk); seen = busy && !load_data; end
    checks++;
    if (!seen || fifo_level !== 4'd3) begin errors++; $display("FAIL midrst_setup: wait_done=%b level=%0d want 1 3", seen, fifo_level); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({load_data, busy, timeout_err, fifo_empty, fifo_full} !== 5'b00010 || fifo_level !== 4'd0 ||
        data_out !== 24'h0 || frames_sent !== 16'h0) begin
      errors++;
      $display("FAIL midrst_state: load=%b busy=%b err=%b empty=%b full=%b level=%0d data=%h frames=%0d, want 0 0 0 1 0 0 000000 0",
               load_data, busy, timeout_err, fifo_empty, fifo_full, fifo_level, data_out, frames_sent);
    end
    @(negedge clk);
    rst_n = 1'b1;
    done_send = 1'b1;
  endtask

  task automatic test_push_pop_same_cycle();
    done_send = 1'b0; do_reset();
    for (int i = 0; i < 4; i++) push_word(24'(24'h10 + i));
    checks++;
    if (fifo_level !== 4'd4) begin errors++; $display("FAIL pp_setup: level=%0d want 4", fifo_level); end
    done_send = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (load_data !== 1'b0 || fifo_level !== 4'd4) begin errors++; $display("FAIL pp_pre: load=%b level=%0d want 0 4", load_data, fifo_level); end
    wr_en = 1'b1; wr_data = 24'h000014;
    @(negedge clk);
    wr_en = 1'b0;
    checks++;
    if (load_data !== 1'b1 || fifo_level !== 4'd4 || data_out !== 24'h000010) begin
      errors++; $display("FAIL pp_level: load=%b level=%0d data=%h want 1 4 000010", load_data, fifo_level, data_out);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_burst();
    test_post_reset_gating();
    test_timeout();
    test_reset_mid_frame();
    test_push_pop_same_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
